// File: rtl/stw_ctrl_pkg.sv
// rtl/stw_ctrl_pkg.sv - state encoding shared by the stopwatch control block
// Contents: state_t, the FSM state encoding, also driven out on the 2-bit debug port.
package stw_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } state_t;

endpackage

// File: rtl/btn_edge_det.sv
// rtl/btn_edge_det.sv - rising-edge detector for one debounced button level
// Ports:
//   CLK   in  system clock
//   rst_n in  asynchronous active-low reset
//   btn   in  debounced button level
//   rise  out one-cycle pulse when btn goes 0 -> 1
module btn_edge_det (
  input  logic CLK,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic prev;

  // prev resets high so a button already held when reset releases is not a press.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/stop_watch_ctrl.sv
// rtl/stop_watch_ctrl.sv - stopwatch control FSM and display time register
// Build option: STOP_WATCH_LAP_EN enables the LAP split state.
// Ports:
//   CLK, rst_n                         clock, asynchronous active-low reset
//   btn_ss, btn_lr                     debounced start/stop and lap/reset levels
//   sw_valid, sw_seconds/mins/hrs      counter-chain update strobe and live values
//   sw_en, sw_stop, sw_rst_counters    counter enable, stop pulse, clear pulse
//   disp_seconds/mins/hrs              time presented to the display
//   lap_active                         high while the display is frozen on a split
//   state                              current FSM state
module stop_watch_ctrl
  import stw_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       sw_valid,
  input  logic [7:0] sw_seconds,
  input  logic [7:0] sw_mins,
  input  logic [7:0] sw_hrs,
  output logic       sw_en,
  output logic       sw_stop,
  output logic       sw_rst_counters,
  output logic [7:0] disp_seconds,
  output logic [7:0] disp_mins,
  output logic [7:0] disp_hrs,
  output logic       lap_active,
  output logic [1:0] state
);

  logic   ss_rise, lr_rise;
  state_t state_q, state_d;
  logic   en_d, stop_d, rst_d, lap_d;
  logic   enter_idle, lap_capture;

  btn_edge_det u_ss_edge (.CLK(CLK), .rst_n(rst_n), .btn(btn_ss), .rise(ss_rise));
  btn_edge_det u_lr_edge (.CLK(CLK), .rst_n(rst_n), .btn(btn_lr), .rise(lr_rise));

  // ss is tested first in every state, so a simultaneous lr edge is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_rise) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_rise) state_d = ST_PAUSED;
`ifdef STOP_WATCH_LAP_EN
        else if (lr_rise) state_d = ST_LAP;
`endif
      end
      ST_PAUSED: begin
        if (ss_rise)      state_d = ST_RUNNING;
        else if (lr_rise) state_d = ST_IDLE;
      end
      ST_LAP: begin
`ifdef STOP_WATCH_LAP_EN
        if (ss_rise)      state_d = ST_PAUSED;
        else if (lr_rise) state_d = ST_RUNNING;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they
    // change on the same edge as the state itself.
    en_d        = (state_d == ST_RUNNING) || (state_d == ST_LAP);
    stop_d      = (state_d == ST_PAUSED) && (state_q != ST_PAUSED);
    rst_d       = (state_q == ST_PAUSED) && (state_d == ST_IDLE);
    enter_idle  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
`ifdef STOP_WATCH_LAP_EN
    lap_d       = (state_d == ST_LAP);
    lap_capture = (state_d == ST_LAP) && (state_q != ST_LAP);
`else
    lap_d       = 1'b0;
    lap_capture = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      sw_en           <= 1'b0;
      sw_stop         <= 1'b0;
      sw_rst_counters <= 1'b0;
      lap_active      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sw_en           <= en_d;
      sw_stop         <= stop_d;
      sw_rst_counters <= rst_d;
      lap_active      <= lap_d;
    end
  end

  // Clearing wins over everything; the split capture ignores sw_valid; live
  // updates are blocked while a split is on display.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      disp_seconds <= 8'h00;
      disp_mins    <= 8'h00;
      disp_hrs     <= 8'h00;
    end else if (enter_idle) begin
      disp_seconds <= 8'h00;
      disp_mins    <= 8'h00;
      disp_hrs     <= 8'h00;
    end else if (lap_capture || (sw_valid && !lap_active)) begin
      disp_seconds <= sw_seconds;
      disp_mins    <= sw_mins;
      disp_hrs     <= sw_hrs;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// tb/tb_stop_watch_ctrl.sv - directed self-checking bench for stop_watch_ctrl
module tb_stop_watch_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b0, btn_lr = 1'b0, sw_valid = 1'b0;
  logic [7:0] sw_seconds = 8'h00, sw_mins = 8'h00, sw_hrs = 8'h00;
  logic       sw_en, sw_stop, sw_rst_counters, lap_active;
  logic [7:0] disp_seconds, disp_mins, disp_hrs;
  logic [1:0] state;

  int cmps = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  stop_watch_ctrl dut (
    .CLK(CLK), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .sw_valid(sw_valid), .sw_seconds(sw_seconds), .sw_mins(sw_mins), .sw_hrs(sw_hrs),
    .sw_en(sw_en), .sw_stop(sw_stop), .sw_rst_counters(sw_rst_counters),
    .disp_seconds(disp_seconds), .disp_mins(disp_mins), .disp_hrs(disp_hrs),
    .lap_active(lap_active), .state(state)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_valid = 1'b1; sw_seconds = 8'h33; sw_mins = 8'h22; sw_hrs = 8'h11;
    step(); step();
    cmps++; if (state !== 2'b00) begin errs++; $display("FAIL rst_state got %b exp 00", state); end
    cmps++; if ({sw_en, sw_stop, sw_rst_counters, lap_active} !== 4'b0000) begin errs++; $display("FAIL rst_ctrl got %b exp 0000", {sw_en, sw_stop, sw_rst_counters, lap_active}); end
    cmps++; if ({disp_hrs, disp_mins, disp_seconds} !== 24'h000000) begin errs++; $display("FAIL rst_disp got %h exp 000000", {disp_hrs, disp_mins, disp_seconds}); end
    sw_valid = 1'b0; sw_seconds = 8'h00; sw_mins = 8'h00; sw_hrs = 8'h00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_lr();
    btn_lr = 1'b1; step();
    cmps++; if (state !== 2'b00) begin errs++; $display("FAIL idle_lr_state got %b exp 00", state); end
    cmps++; if (sw_rst_counters !== 1'b0) begin errs++; $display("FAIL idle_lr_rst got %b exp 0", sw_rst_counters); end
    btn_lr = 1'b0; step();
  endtask

  task automatic test_start();
    btn_ss = 1'b1; step();
    cmps++; if (state !== 2'b01) begin errs++; $display("FAIL start_state got %b exp 01", state); end
    cmps++; if ({sw_en, sw_stop, sw_rst_counters} !== 3'b100) begin errs++; $display("FAIL start_ctrl got %b exp 100", {sw_en, sw_stop, sw_rst_counters}); end
    step();
    cmps++; if (state !== 2'b01) begin errs++; $display("FAIL start_held got %b exp 01", state); end
    btn_ss = 1'b0; step();
  endtask

  task automatic test_live_display();
    sw_valid = 1'b1; sw_seconds = 8'h05; sw_mins = 8'h02; sw_hrs = 8'h00; step();
    cmps++; if ({disp_hrs, disp_mins, disp_seconds} !== 24'h000205) begin errs++; $display("FAIL live_load got %h exp 000205", {disp_hrs, disp_mins, disp_seconds}); end
    sw_valid = 1'b0; sw_seconds = 8'h09; step();
    cmps++; if (disp_seconds !== 8'h05) begin errs++; $display("FAIL live_hold got %h exp 05", disp_seconds); end
    sw_valid = 1'b1; step();
    cmps++; if (disp_seconds !== 8'h09) begin errs++; $display("FAIL live_update got %h exp 09", disp_seconds); end
    sw_valid = 1'b0;
  endtask

`ifdef STOP_WATCH_LAP_EN
  task automatic test_lap();
    sw_valid = 1'b1; sw_seconds = 8'h05; sw_mins = 8'h02; sw_hrs = 8'h00;
    btn_lr = 1'b1; step();
    cmps++; if ({state, lap_active, sw_en} !== 4'b1111) begin errs++; $display("FAIL lap_enter got %b exp 1111", {state, lap_active, sw_en}); end
    cmps++; if ({disp_hrs, disp_mins, disp_seconds} !== 24'h000205) begin errs++; $display("FAIL lap_capture got %h exp 000205", {disp_hrs, disp_mins, disp_seconds}); end
    btn_lr = 1'b0; sw_seconds = 8'h09; step(); step();
    cmps++; if (disp_seconds !== 8'h05) begin errs++; $display("FAIL lap_frozen got %h exp 05", disp_seconds); end
    sw_valid = 1'b0; btn_lr = 1'b1; step();
    cmps++; if ({state, lap_active} !== 3'b010) begin errs++; $display("FAIL lap_exit got %b exp 010", {state, lap_active}); end
    btn_lr = 1'b0; sw_valid = 1'b1; sw_seconds = 8'h0A; step();
    cmps++; if (disp_seconds !== 8'h0A) begin errs++; $display("FAIL lap_relive got %h exp 0a", disp_seconds); end
    sw_valid = 1'b0;
  endtask
`else
  task automatic test_no_lap();
    btn_lr = 1'b1; step();
    cmps++; if ({state, lap_active} !== 3'b010) begin errs++; $display("FAIL nolap_state got %b exp 010", {state, lap_active}); end
    btn_lr = 1'b0; sw_valid = 1'b1; sw_seconds = 8'h0A; step();
    cmps++; if ({disp_seconds, lap_active} !== 9'h014) begin errs++; $display("FAIL nolap_live got %h exp 014", {disp_seconds, lap_active}); end
    sw_valid = 1'b0;
  endtask
`endif

  task automatic test_pause_clear();
    btn_ss = 1'b1; step();
    cmps++; if ({state, sw_stop, sw_en} !== 4'b1010) begin errs++; $display("FAIL pause_enter got %b exp 1010", {state, sw_stop, sw_en}); end
    btn_ss = 1'b0; step();
    cmps++; if ({state, sw_stop} !== 3'b100) begin errs++; $display("FAIL pause_pulse_end got %b exp 100", {state, sw_stop}); end
    btn_lr = 1'b1; step();
    cmps++; if ({state, sw_rst_counters} !== 3'b001) begin errs++; $display("FAIL clear_enter got %b exp 001", {state, sw_rst_counters}); end
    cmps++; if ({disp_hrs, disp_mins, disp_seconds} !== 24'h000000) begin errs++; $display("FAIL clear_disp got %h exp 000000", {disp_hrs, disp_mins, disp_seconds}); end
    btn_lr = 1'b0; step();
    cmps++; if (sw_rst_counters !== 1'b0) begin errs++; $display("FAIL clear_pulse_end got %b exp 0", sw_rst_counters); end
  endtask

  task automatic test_back_to_back();
    btn_ss = 1'b1; step(); btn_ss = 1'b0; step();
    sw_valid = 1'b1; sw_seconds = 8'h11; step();
    sw_valid = 1'b0; sw_seconds = 8'h22;
    btn_ss = 1'b1; btn_lr = 1'b1; step();
    cmps++; if ({state, lap_active, sw_stop} !== 4'b1001) begin errs++; $display("FAIL simul_state got %b exp 1001", {state, lap_active, sw_stop}); end
    cmps++; if (disp_seconds !== 8'h11) begin errs++; $display("FAIL simul_nocap got %h exp 11", disp_seconds); end
    btn_ss = 1'b0; btn_lr = 1'b0; step();
    btn_ss = 1'b1; step();
    cmps++; if ({state, sw_en} !== 3'b011) begin errs++; $display("FAIL resume got %b exp 011", {state, sw_en}); end
    btn_ss = 1'b0; step();
  endtask

  task automatic test_async_reset_held();
    btn_ss = 1'b1; step();
    cmps++; if (sw_stop !== 1'b1) begin errs++; $display("FAIL pre_areset_stop got %b exp 1", sw_stop); end
    #2 rst_n = 1'b0;
    #1;
    cmps++; if ({state, sw_stop, sw_en, disp_seconds} !== 12'h000) begin errs++; $display("FAIL areset got %h exp 000", {state, sw_stop, sw_en, disp_seconds}); end
    step(); rst_n = 1'b1; step(); step();
    cmps++; if (state !== 2'b00) begin errs++; $display("FAIL held_thru_reset got %b exp 00", state); end
    btn_ss = 1'b0; step();
    cmps++; if (state !== 2'b00) begin errs++; $display("FAIL held_release got %b exp 00", state); end
    btn_ss = 1'b1; step();
    cmps++; if (state !== 2'b01) begin errs++; $display("FAIL held_repress got %b exp 01", state); end
    btn_ss = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_idle_lr();
    test_start();
    test_live_display();
`ifdef STOP_WATCH_LAP_EN
    test_lap();
`else
    test_no_lap();
`endif
    test_pause_clear();
    test_back_to_back();
    test_async_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
